// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: multi-channel LED pattern generator (OFF/ON/BLINK/BURST) driven by a shared tick.
// Define LED_PWM_DIM_EN to add per-channel PWM dimming through cfg_duty.
module led_pattern_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 24,
  parameter int BURST_W  = 4,
  parameter int PWM_W    = 4,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [BURST_W-1:0] cfg_burst,
`ifdef LED_PWM_DIM_EN
  input  logic [PWM_W-1:0]   cfg_duty,
`endif
  output logic               tick,
  output logic [NUM_CH-1:0]  led,
  output logic [NUM_CH-1:0]  busy
);
  typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BURST} mode_t;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  if (NUM_CH < 1 || PRESCALE < 1 || PWM_W < 1) begin : g_bad_param
    $error("led_pattern_ctrl: NUM_CH, PRESCALE and PWM_W must be >= 1");
  end

  logic [PW-1:0] r_pre;
  logic          r_tick;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= (r_pre == PMAX) ? '0 : r_pre + 1'b1;
      r_tick <= r_pre == PMAX;
    end

  assign tick = r_tick;

`ifdef LED_PWM_DIM_EN
  logic [PWM_W-1:0] r_pwm;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pwm <= '0;
    else r_pwm <= r_pwm + 1'b1;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mode_t              r_mode, w_mode;
    logic [CNT_W-1:0]   r_per, w_per, r_ph, w_ph;
    logic [BURST_W-1:0] r_rem, w_rem;
    logic               r_st, w_st, r_bsy, w_bsy;
    logic               w_wr, w_last, w_bst;

    assign w_wr   = cfg_we && cfg_ch == CH_W'(g);
    assign w_bst  = cfg_mode == M_BURST && cfg_burst != '0;
    // period 0 behaves as 1, so the wrap point is period-1 clamped at 0
    assign w_last = r_ph == (r_per - CNT_W'(r_per != '0));

    always_comb begin
      w_mode = r_mode;
      w_per  = r_per;
      w_ph   = r_ph;
      w_rem  = r_rem;
      w_st   = r_st;
      w_bsy  = r_bsy;
      if (w_wr) begin
        w_mode = (cfg_mode == M_BURST && !w_bst) ? M_OFF : mode_t'(cfg_mode);
        w_per  = cfg_period;
        w_ph   = '0;
        w_rem  = cfg_burst;
        w_st   = cfg_mode == M_ON || w_bst;
        w_bsy  = w_bst;
      end else if (r_tick && (r_mode == M_BLINK || r_mode == M_BURST)) begin
        w_ph = w_last ? '0 : r_ph + 1'b1;
        if (w_last) begin
          if (r_mode == M_BLINK) w_st = !r_st;
          else if (r_st) begin
            w_st  = 1'b0;
            w_rem = r_rem - 1'b1;
          end else if (r_rem == '0) begin
            w_mode = M_OFF;
            w_bsy  = 1'b0;
          end else w_st = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_mode <= M_OFF;
        r_per  <= '0;
        r_ph   <= '0;
        r_rem  <= '0;
        r_st   <= 1'b0;
        r_bsy  <= 1'b0;
      end else begin
        r_mode <= w_mode;
        r_per  <= w_per;
        r_ph   <= w_ph;
        r_rem  <= w_rem;
        r_st   <= w_st;
        r_bsy  <= w_bsy;
      end

    assign busy[g] = r_bsy;

`ifdef LED_PWM_DIM_EN
    logic [PWM_W-1:0] r_duty;
    logic             r_led;

    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_duty <= '1;
        r_led  <= 1'b0;
      end else begin
        if (w_wr) r_duty <= cfg_duty;
        r_led <= w_st && r_pwm < (w_wr ? cfg_duty : r_duty);
      end

    assign led[g] = r_led;
`else
    assign led[g] = r_st;
`endif
  end
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: scoreboard bench; expected tick/led/busy pushed per driven cycle, popped on the next negedge.
module tb_led_pattern_ctrl;
  localparam int NC = 2, CW = 4, PS = 2, BW = 4;
  logic          clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0;
  logic [0:0]    cfg_ch = '0;
  logic [1:0]    cfg_mode = '0;
  logic [CW-1:0] cfg_period = '0;
  logic [BW-1:0] cfg_burst = '0;
  logic          tick;
  logic [NC-1:0] led, busy;
  logic          b_we = 1'b0, b_tick;
  logic [1:0]    b_ch = '0, b_mode = '0;
  logic [2:0]    b_led, b_busy;
`ifdef LED_PWM_DIM_EN
  logic [3:0]    cfg_duty = '1;
  int            m_duty[NC];
`endif
  int            m_cyc, m_per[NC], m_bur[NC], m_t[NC];
  logic [1:0]    m_mode[NC];
  logic          m_tick, m_tcur;
  logic [4:0]    m_exp, e;
  logic [4:0]    q[$];
  int            n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  led_pattern_ctrl #(.NUM_CH(NC), .CNT_W(CW), .PRESCALE(PS), .BURST_W(BW), .PWM_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_burst(cfg_burst),
`ifdef LED_PWM_DIM_EN
    .cfg_duty(cfg_duty),
`endif
    .tick(tick), .led(led), .busy(busy));

  // three-channel instance so that an out-of-range channel index is expressible
  led_pattern_ctrl #(.NUM_CH(3), .CNT_W(CW), .PRESCALE(PS), .BURST_W(BW), .PWM_W(4)) u_inv (
    .clk(clk), .rst_n(rst_n), .cfg_we(b_we), .cfg_ch(b_ch), .cfg_mode(b_mode),
    .cfg_period(cfg_period), .cfg_burst(cfg_burst),
`ifdef LED_PWM_DIM_EN
    .cfg_duty(cfg_duty),
`endif
    .tick(b_tick), .led(b_led), .busy(b_busy));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic m_rst();
    m_cyc = 0;
    m_tick = 1'b0;
    for (int c = 0; c < NC; c++) begin
      m_mode[c] = 2'd0;
      m_per[c] = 1;
      m_bur[c] = 0;
      m_t[c] = 0;
`ifdef LED_PWM_DIM_EN
      m_duty[c] = 15;
`endif
    end
    q.delete();
  endtask

  // drive one cycle's inputs and push what the outputs must be after the next edge
  task automatic step(input logic we, input int ch, input logic [1:0] mode, input int per, input int bur, input int duty);
    logic [NC-1:0] el, eb;
    int k;
    cfg_we = we;
    cfg_ch = 1'(ch);
    cfg_mode = mode;
    cfg_period = CW'(per);
    cfg_burst = BW'(bur);
`ifdef LED_PWM_DIM_EN
    cfg_duty = 4'(duty);
`endif
    m_cyc++;
    m_tcur = m_tick;
    for (int c = 0; c < NC; c++) begin
      if (we && ch == c) begin
        m_mode[c] = mode;
        m_per[c] = (per == 0) ? 1 : per;
        m_bur[c] = bur;
        m_t[c] = 0;
`ifdef LED_PWM_DIM_EN
        m_duty[c] = duty;
`endif
      end else if (m_tcur) m_t[c]++;
      k = m_t[c] / m_per[c];
      eb[c] = m_mode[c] == 2'd3 && k < 2 * m_bur[c];
      el[c] = m_mode[c] == 2'd1 || (m_mode[c] == 2'd2 && k % 2 == 1) || (eb[c] && k % 2 == 0);
`ifdef LED_PWM_DIM_EN
      el[c] = el[c] && ((m_cyc - 1) % 16) < m_duty[c];
`endif
    end
    m_tick = (m_cyc % PS) == 0;
    m_exp = {m_tick, el, eb};
    q.push_back(m_exp);
    if (duty < 0) $display("negative duty ignored");
  endtask

  task automatic cyc(input logic we, input int ch, input logic [1:0] mode, input int per, input int bur, input int duty = 15);
    @(negedge clk);
    #1;
    step(we, ch, mode, per, bur, duty);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 2'd0, 0, 0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    m_rst();
    step(1'b0, 0, 2'd0, 0, 0, 15);
  endtask

  always @(negedge clk)
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      chk("tick", 8'(tick), 8'(e[4]));
      chk("led", 8'(led), 8'(e[3:2]));
      chk("busy", 8'(busy), 8'(e[1:0]));
    end

  initial begin
    m_rst();
    #12;
    chk("rst_tick", 8'(tick), 8'd0);
    chk("rst_led", 8'(led), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    release_rst();
    idle(5);
    cyc(1'b1, 0, 2'd2, 3, 0);
    idle(16);
    cyc(1'b1, 1, 2'd3, 1, 3);
    idle(18);
    for (int i = 0; i < 20 && !m_exp[2]; i++) idle(1);
    @(posedge clk);
    #2;
    chk("pre_rst_led0", 8'(led[0]), 8'(m_exp[2]));
    rst_n = 1'b0;
    #1;
    chk("arst_led", 8'(led), 8'd0);
    chk("arst_busy", 8'(busy), 8'd0);
    chk("arst_tick", 8'(tick), 8'd0);
    repeat (2) @(negedge clk);
    chk("hold_led", 8'(led), 8'd0);
    chk("hold_busy", 8'(busy), 8'd0);
    release_rst();
    idle(3);
    cyc(1'b1, 0, 2'd2, 0, 0);
    cyc(1'b1, 1, 2'd2, 1, 0);
    idle(5);
    for (int i = 0; i < 4 && !m_tick; i++) idle(1);
    cyc(1'b1, 0, 2'd1, 0, 0);
    idle(4);
    b_we = 1'b1;
    b_ch = 2'd3;
    b_mode = 2'd1;
    idle(1);
    b_we = 1'b0;
    chk("inv_ch3_led", 8'(b_led), 8'd0);
    chk("inv_ch3_busy", 8'(b_busy), 8'd0);
    chk("inv_tick", 8'(b_tick), 8'(m_tcur));
    b_we = 1'b1;
    b_ch = 2'd2;
    idle(1);
    b_we = 1'b0;
    chk("inv_ch2_led", 8'(b_led), 8'b100);
    cyc(1'b1, 0, 2'd3, 1, 0);
    idle(6);
    cyc(1'b1, 1, 2'd3, 2, 4);
    idle(5);
    cyc(1'b1, 1, 2'd0, 0, 0);
    idle(3);
`ifdef LED_PWM_DIM_EN
    cyc(1'b1, 0, 2'd1, 0, 0, 4);
    idle(32);
    cyc(1'b1, 0, 2'd1, 0, 0, 0);
    idle(16);
`endif
    @(negedge clk);
    #1;
    chk("drain", 8'(q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
